// File: rtl/rng_word_arbiter.sv
// Round-robin arbiter sharing one serial RNG bit stream among NREQ requesters.
// Optional `RNG_DENSITY_EN adds a density threshold input and a registered word_hit output.
`timescale 1ns/1ps
module rng_word_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rng_bit,
  output logic             rng_step,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] word_data,
  output logic             busy,
`ifdef RNG_DENSITY_EN
  input  logic [WIDTH-1:0] density,
  output logic             word_hit,
`endif
  output logic [1:0]       dbg_state
);

  localparam int LW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LW-1:0]     r_win;
  logic [LW-1:0]     r_last;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic [WIDTH-1:0]  r_shift;
  logic [WIDTH-1:0]  r_word;
  logic [CW-1:0]     r_cnt;

  logic              w_found;
  logic [LW-1:0]     w_pick;
  logic [LW-1:0]     w_cand;
  logic [NREQ-1:0]   w_pick_oh;
  logic [WIDTH-1:0]  w_shift_nxt;
  logic              w_abort;
  logic              w_last_sample;
  logic              w_capture;

  // Search starts just after the last winner, so a re-requester lands at lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = LW'((int'(r_last) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_pick_oh     = NREQ'(1) << w_pick;
  assign w_shift_nxt   = {r_shift[WIDTH-2:0], rng_bit};
  assign w_abort       = (r_state == S_COLLECT) && !req[r_win];
  assign w_last_sample = (r_cnt == CW'(WIDTH - 1));
  assign w_capture     = (r_state == S_COLLECT) && !w_abort && w_last_sample;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_found) w_next = S_COLLECT;
      S_COLLECT: begin
        if (w_abort)            w_next = S_IDLE;
        else if (w_last_sample) w_next = S_DONE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_word  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_win   <= '0;
      r_last  <= LW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      r_ack   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win   <= w_pick;
            r_gnt   <= w_pick_oh;
            r_shift <= '0;
            r_cnt   <= '0;
          end
        end
        S_COLLECT: begin
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + CW'(1);
          // ack and word are loaded together so they appear in the DONE cycle.
          if (w_abort) begin
            r_gnt <= '0;
          end else if (w_last_sample) begin
            r_ack  <= r_gnt;
            r_word <= w_shift_nxt;
          end
        end
        S_DONE: begin
          r_last <= r_win;
          r_gnt  <= '0;
        end
        default: r_gnt <= '0;
      endcase
    end
  end

`ifdef RNG_DENSITY_EN
  logic r_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= 1'b0;
    end else if (w_capture) begin
      r_hit <= (w_shift_nxt < density);
    end
  end

  assign word_hit = r_hit;
`endif

  assign rng_step  = (r_state == S_COLLECT);
  assign busy      = (r_state != S_IDLE);
  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign word_data = r_word;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rng_word_arbiter.sv
// Bench for rng_word_arbiter: directed scenarios plus random traffic, checked by a
// time-based reference model feeding an expected-ack queue.
`timescale 1ns/1ps
module tb_rng_word_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int EW    = NREQ + WIDTH + 1;

  // clock / reset / DUT
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rng_bit = 1'b0;
  logic             rng_step;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] word_data;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef RNG_DENSITY_EN
  logic [WIDTH-1:0] density = '0;
  logic             word_hit;
`endif

  always #5 clk = ~clk;

  rng_word_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rng_bit   (rng_bit),
    .rng_step  (rng_step),
    .req       (req),
    .gnt       (gnt),
    .ack       (ack),
    .word_data (word_data),
    .busy      (busy),
`ifdef RNG_DENSITY_EN
    .density   (density),
    .word_hit  (word_hit),
`endif
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a word is granted at edge s, collects bits at edges s+1..s+WIDTH,
  // acks in the cycle after edge s+WIDTH and frees the arbiter at edge s+WIDTH+1.
  int               m_edge   = 0;
  bit               m_active = 1'b0;
  int               m_win    = 0;
  int               m_start  = 0;
  int               m_last   = NREQ - 1;
  int               m_word   = 0;
  int               m_k      = 0;
  int               m_idx    = 0;
  logic             m_hit    = 1'b0;
  logic [WIDTH-1:0] m_hold   = '0;
  logic             m_hit_hold = 1'b0;
  logic [NREQ-1:0]  m_oh;
  logic [EW-1:0]    exp_q[$];
  int               exp_t[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active   = 1'b0;
      m_last     = NREQ - 1;
      m_hold     = '0;
      m_hit_hold = 1'b0;
      exp_q.delete();
      exp_t.delete();
    end else begin
      m_edge++;
      if (m_active) begin
        m_k = m_edge - m_start;
        if (m_k <= WIDTH) begin
          if (!req[m_win]) begin
            m_active = 1'b0;
          end else begin
            m_word = m_word * 2 + int'(rng_bit);
            if (m_k == WIDTH) begin
`ifdef RNG_DENSITY_EN
              m_hit = (m_word < int'(density));
`else
              m_hit = 1'b0;
`endif
              m_hold     = WIDTH'(m_word);
              m_hit_hold = m_hit;
              m_oh       = '0;
              m_oh[m_win] = 1'b1;
              exp_q.push_back({m_oh, m_hold, m_hit});
              exp_t.push_back(m_edge);
            end
          end
        end else begin
          m_last   = m_win;
          m_active = 1'b0;
        end
      end else if (req != '0) begin
        for (int off = 1; off <= NREQ; off++) begin
          m_idx = (m_last + off) % NREQ;
          if (!m_active && req[m_idx]) begin
            m_active = 1'b1;
            m_win    = m_idx;
            m_start  = m_edge;
            m_word   = 0;
          end
        end
      end
    end
  end

  // scoreboard monitor, sampling on the falling edge
  logic [EW-1:0]   mon_item;
  logic [NREQ-1:0] mon_ack;
  logic [NREQ-1:0] mon_gnt;

  always @(negedge clk) begin
    if (rst_n) begin
      mon_ack = '0;
      if (exp_t.size() > 0 && exp_t[0] == m_edge) begin
        mon_item = exp_q.pop_front();
        void'(exp_t.pop_front());
        mon_ack  = mon_item[EW-1 -: NREQ];
        chk("sb_word", 32'(word_data), 32'(mon_item[WIDTH:1]));
`ifdef RNG_DENSITY_EN
        chk("sb_hit", 32'(word_hit), 32'(mon_item[0]));
`endif
      end
      chk("sb_ack", 32'(ack), 32'(mon_ack));
      mon_gnt = '0;
      if (m_active) mon_gnt[m_win] = 1'b1;
      chk("sb_gnt", 32'(gnt), 32'(mon_gnt));
      chk("sb_busy", 32'(busy), 32'(m_active));
      chk("sb_step", 32'(rng_step), 32'(m_active && ((m_edge - m_start) < WIDTH)));
      chk("sb_hold", 32'(word_data), 32'(m_hold));
`ifdef RNG_DENSITY_EN
      chk("sb_hit_hold", 32'(word_hit), 32'(m_hit_hold));
`endif
    end
  end

  // driver tasks
  bit rand_bits = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bits) rng_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (ack != '0) begin
        for (int j = 0; j < NREQ; j++) if (ack[j]) idx = j;
        return;
      end
    end
    chk("ack_timeout", 32'(0), 32'(1));
  endtask

  // Requester 0 asks for one word while the bench drives the given bit pattern MSB first.
  task automatic run_word(input logic [WIDTH-1:0] w, output int steps);
    rand_bits = 1'b0;
    req[0] = 1'b1;
    tick();
    steps = 0;
    for (int i = 0; i < WIDTH; i++) begin
      rng_bit = w[WIDTH-1-i];
      if (rng_step) steps++;
      tick();
    end
    rand_bits = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog at %0t: bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  int idx;
  int steps;
  int gap;
  logic [WIDTH-1:0] saved;
  logic [NREQ-1:0]  acc;

  initial begin
    // reset state and the single-request word
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_word", 32'(word_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_step", 32'(rng_step), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(0));

    run_word(8'hB2, steps);
    chk("single_steps", 32'(steps), 32'(8));
    chk("single_ack", 32'(ack), 32'(4'b0001));
    chk("single_word", 32'(word_data), 32'(8'hB2));
    chk("single_step_off", 32'(rng_step), 32'(0));
    req = '0;
    tick();
    tick();
    chk("single_held", 32'(word_data), 32'(8'hB2));

    // round-robin with all requesters
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      wait_ack(idx);
      chk("rr_order", 32'(idx), 32'(n));
      if (idx >= 0) req[idx] = 1'b0;
      if (n < NREQ - 1) begin
        gap = 0;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (busy) break;
          gap++;
        end
        chk("rr_gap", 32'(gap), 32'(1));
      end
    end
    tick();

    // re-request goes to the back of the line
    do_reset();
    req = 4'b0011;
    wait_ack(idx);
    chk("rereq_first", 32'(idx), 32'(0));
    wait_ack(idx);
    chk("rereq_second", 32'(idx), 32'(1));
    req[1] = 1'b0;
    wait_ack(idx);
    chk("rereq_third", 32'(idx), 32'(0));
    req = '0;
    tick();

    // abort leaves word_data and the pointer alone
    do_reset();
    req = 4'b0010;
    wait_ack(idx);
    chk("abort_pre", 32'(idx), 32'(1));
    req = '0;
    tick();
    saved = word_data;
    req = 4'b0100;
    tick();
    chk("abort_gnt", 32'(gnt), 32'(4'b0100));
    repeat (3) tick();
    req = '0;
    tick();
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_gnt_clr", 32'(gnt), 32'(0));
    chk("abort_word", 32'(word_data), 32'(saved));
    acc = '0;
    repeat (WIDTH + 2) begin
      tick();
      acc = acc | ack;
    end
    chk("abort_noack", 32'(acc), 32'(0));
    req = 4'b1100;
    tick();
    chk("abort_last", 32'(gnt), 32'(4'b0100));
    wait_ack(idx);
    chk("abort_regrant", 32'(idx), 32'(2));
    req = '0;
    repeat (3) tick();

    // asynchronous reset in the middle of a collection
    req = 4'b1000;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'(0));
    chk("arst_ack", 32'(ack), 32'(0));
    chk("arst_step", 32'(rng_step), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    req = '0;
    tick();
    tick();
    rst_n = 1'b1;
    req = 4'b1000;
    tick();
    chk("arst_regnt", 32'(gnt), 32'(4'b1000));
    wait_ack(idx);
    chk("arst_ack3", 32'(idx), 32'(3));
    req = '0;
    tick();
    req = 4'b1001;
    tick();
    chk("arst_rr", 32'(gnt), 32'(4'b0001));
    wait_ack(idx);
    chk("arst_first0", 32'(idx), 32'(0));
    req[0] = 1'b0;
    wait_ack(idx);
    chk("arst_then3", 32'(idx), 32'(3));
    req = '0;
    tick();

`ifdef RNG_DENSITY_EN
    // density threshold boundaries
    do_reset();
    density = 8'h80;
    run_word(8'h7F, steps);
    chk("dens_7f", 32'(word_hit), 32'(1));
    req = '0;
    tick();
    run_word(8'h80, steps);
    chk("dens_80", 32'(word_hit), 32'(0));
    req = '0;
    tick();
    density = 8'h00;
    run_word(8'h00, steps);
    chk("dens_zero", 32'(word_hit), 32'(0));
    req = '0;
    tick();
    density = 8'hFF;
    run_word(8'hFE, steps);
    chk("dens_ff_fe", 32'(word_hit), 32'(1));
    req = '0;
    tick();
    run_word(8'hFF, steps);
    chk("dens_ff_ff", 32'(word_hit), 32'(0));
    req = '0;
    tick();
`endif

    // random traffic: hold until ack, sometimes re-request, occasionally abort
    do_reset();
    rand_bits = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (ack[i]) req[i] = ($urandom_range(0, 2) == 0);
          else if (gnt[i] && $urandom_range(0, 59) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
`ifdef RNG_DENSITY_EN
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 2))
          0:       density = '0;
          1:       density = '1;
          default: density = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        endcase
      end
`endif
      tick();
    end
    req = '0;
    repeat (WIDTH + 4) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
